// File: rtl/featuremap_pad_writer.sv
// Streams one zero-padded feature map frame ((WIDTH+2) x (HEIGHT+2) words) into a channel FIFO.
// Define FEATUREMAP_PAD_RELU_EN to clamp negative interior pixels to zero.
module featuremap_pad_writer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIDTH      = 56,
    parameter int unsigned HEIGHT     = 56
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  in_ready,
    input  logic                  fifo_full,
    output logic                  wrreq,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  frame_done
);

    localparam int unsigned COL_W = $clog2(WIDTH + 2);
    localparam int unsigned ROW_W = $clog2(HEIGHT + 2);

    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(WIDTH + 1);
    localparam logic [COL_W-1:0] COL_DATA_LAST = COL_W'(WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(HEIGHT + 1);
    localparam logic [ROW_W-1:0] ROW_DATA_LAST = ROW_W'(HEIGHT);

    typedef enum logic [1:0] {StIdle, StPad, StData, StDone} state_t;

    state_t                state_q;
    logic [ROW_W-1:0]      row_q;
    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_nxt;
    logic [COL_W-1:0]      col_nxt;
    logic                  next_interior;
    logic                  accept;
    logic [DATA_WIDTH-1:0] pixel;

    // Raster successor of the current position; row overflow past the last row is never used.
    always_comb begin
        if (col_q == COL_LAST) begin
            col_nxt = '0;
            row_nxt = row_q + ROW_W'(1);
        end else begin
            col_nxt = col_q + COL_W'(1);
            row_nxt = row_q;
        end
        next_interior = (row_nxt != '0) && (row_nxt <= ROW_DATA_LAST) &&
                        (col_nxt != '0) && (col_nxt <= COL_DATA_LAST);
    end

`ifdef FEATUREMAP_PAD_RELU_EN
    assign pixel = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
    assign pixel = data_in;
`endif

    assign in_ready = (state_q == StData) && !fifo_full;
    assign accept   = valid_in && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            wrreq      <= 1'b0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wrreq      <= 1'b0;
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The pixel that wakes us stays upstream until the first interior slot.
                    if (valid_in) begin
                        state_q <= StPad;
                        row_q   <= '0;
                        col_q   <= '0;
                    end
                end
                StPad: begin
                    if (!fifo_full) begin
                        wrreq   <= 1'b1;
                        wr_data <= '0;
                        row_q   <= row_nxt;
                        col_q   <= col_nxt;
                        if (row_q == ROW_LAST && col_q == COL_LAST) begin
                            state_q <= StDone;
                        end else if (next_interior) begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        wrreq   <= 1'b1;
                        wr_data <= pixel;
                        row_q   <= row_nxt;
                        col_q   <= col_nxt;
                        if (col_q == COL_DATA_LAST) begin
                            state_q <= StPad;
                        end
                    end
                end
                StDone: begin
                    frame_done <= 1'b1;
                    state_q    <= StIdle;
                    row_q      <= '0;
                    col_q      <= '0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_featuremap_pad_writer.sv
// Randomized self-checking bench for featuremap_pad_writer: a 2x2 instance against a
// position/queue model plus literal frames, and a default 56x56 instance for frame totals.
module tb_featuremap_pad_writer;

    localparam int W      = 2;
    localparam int H      = 2;
    localparam int TOTAL  = (W + 2) * (H + 2);
    localparam int BW     = 56;
    localparam int BH     = 56;
    localparam int BTOTAL = (BW + 2) * (BH + 2);

    localparam logic [31:0] GOLDEN [16] = '{
        32'h0, 32'h0, 32'h0, 32'h0,
        32'h0, 32'h3F80_0000, 32'h4000_0000, 32'h0,
        32'h0, 32'h4040_0000, 32'h4080_0000, 32'h0,
        32'h0, 32'h0, 32'h0, 32'h0
    };

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid_in, in_ready, fifo_full, wrreq, frame_done;
    logic [31:0] data_in, wr_data;
    logic        b_valid, b_ready, b_full, b_wrreq, b_frame_done;
    logic [31:0] b_data, b_wr_data;

    featuremap_pad_writer #(.DATA_WIDTH(32), .WIDTH(W), .HEIGHT(H)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .in_ready   (in_ready),
        .fifo_full  (fifo_full),
        .wrreq      (wrreq),
        .wr_data    (wr_data),
        .frame_done (frame_done)
    );

    featuremap_pad_writer u_big (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (b_valid),
        .data_in    (b_data),
        .in_ready   (b_ready),
        .fifo_full  (b_full),
        .wrreq      (b_wrreq),
        .wr_data    (b_wr_data),
        .frame_done (b_frame_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_ok(input string name, input bit ok, input logic [31:0] act,
                            input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_ok(name, act === exp, act, exp);
    endtask

    function automatic logic [31:0] relu(input logic [31:0] d);
`ifdef FEATUREMAP_PAD_RELU_EN
        return d[31] ? 32'h0 : d;
`else
        return d;
`endif
    endfunction

    function automatic bit is_border(input int p, input int w, input int h);
        int r, c;
        r = p / (w + 2);
        c = p % (w + 2);
        return (r == 0) || (r == h + 1) || (c == 0) || (c == w + 1);
    endfunction

    // Model state for the small instance: frame position and accepted-but-unwritten pixels.
    int          pos = 0;
    int          cyc = 0;
    int          last_wr_cyc = -10;
    int          frames_done = 0;
    bit          rst_prev = 0;
    bit          prev_full = 0;
    logic [31:0] pix_q [$];
    logic [31:0] cap_q [$];
    logic [31:0] tx_q [$];

    initial begin
        logic [31:0] exp;
        forever begin
            @(negedge clk);
            if (rst_prev) begin
                check("reset_wrreq", 32'(wrreq), 0);
                check("reset_wr_data", wr_data, 0);
                check("reset_frame_done", 32'(frame_done), 0);
                check("reset_in_ready", 32'(in_ready), 0);
            end
            if (prev_full) check("stall_no_write", 32'(wrreq), 0);
            if (fifo_full) check("ready_low_when_full", 32'(in_ready), 0);
            if (wrreq === 1'b1) begin
                cap_q.push_back(wr_data);
                check_ok("write_within_frame", pos < TOTAL, pos, TOTAL - 1);
                if (pos < TOTAL) begin
                    if (is_border(pos, W, H)) begin
                        check("border_word", wr_data, 0);
                    end else begin
                        check_ok("pixel_available", pix_q.size() > 0, pix_q.size(), 1);
                        if (pix_q.size() > 0) begin
                            exp = relu(pix_q.pop_front());
                            check("interior_word", wr_data, exp);
                        end
                    end
                end
                pos++;
                last_wr_cyc = cyc;
            end
            if (frame_done === 1'b1) begin
                check("done_position", pos, TOTAL);
                check("done_after_last_write", cyc - last_wr_cyc, 1);
                check("done_no_leftover", pix_q.size(), 0);
                pos = 0;
                frames_done++;
            end
            if (rst) begin
                pos = 0;
                pix_q.delete();
            end else if (valid_in && in_ready) begin
                pix_q.push_back(data_in);
            end
            rst_prev  = rst;
            prev_full = fifo_full && !rst;
            cyc++;
        end
    end

    int          b_pos = 0, b_writes = 0, b_hs = 0, b_dones = 0;
    logic [31:0] b_pix_q [$];
    logic [31:0] btx [$];

    initial begin
        forever begin
            @(negedge clk);
            if (b_wrreq === 1'b1) begin
                b_writes++;
                if (b_pos < BTOTAL && is_border(b_pos, BW, BH)) begin
                    check("big_border", b_wr_data, 0);
                end else if (b_pix_q.size() > 0) begin
                    check("big_pixel", b_wr_data, relu(b_pix_q.pop_front()));
                end
                b_pos++;
            end
            if (b_frame_done === 1'b1) begin
                b_dones++;
                b_pos = 0;
            end
            if (rst) begin
                b_pos = 0;
                b_pix_q.delete();
            end else if (b_valid && b_ready) begin
                b_pix_q.push_back(b_data);
                b_hs++;
            end
        end
    end

    int stall_pct  = 0;
    int stall_hold = 0;

    initial begin
        fifo_full = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_hold > 0) begin
                fifo_full = 1'b1;
                stall_hold--;
            end else begin
                fifo_full = (int'($urandom_range(99)) < stall_pct);
            end
        end
    end

    // Drives tx_q upstream; optional 3-cycle stall at a frame position, optional reset abort.
    task automatic send_frames(input int nframes, input int gap_max, input bit gap_rand,
                               input int stall_at, input int abort_at);
        int gap = 0;
        int budget = 2000 * nframes;
        int f0 = frames_done;
        bit stalled = 0;
        bit aborted = 0;
        while (tx_q.size() > 0 && budget > 0 && !aborted) begin
            valid_in = (gap == 0);
            data_in  = valid_in ? tx_q[0] : $urandom;
            @(negedge clk);
            if (valid_in && in_ready) begin
                void'(tx_q.pop_front());
                gap = gap_rand ? int'($urandom_range(gap_max)) : gap_max;
            end else if (gap > 0) begin
                gap--;
            end
            if (stall_at >= 0 && !stalled && pos == stall_at) begin
                stall_hold = 3;
                stalled = 1;
            end
            if (abort_at > 0 && pos >= abort_at) aborted = 1;
            @(posedge clk);
            #1;
            budget--;
        end
        valid_in = 1'b0;
        if (aborted) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            tx_q.delete();
        end else begin
            while (frames_done < f0 + nframes && budget > 0) begin
                @(posedge clk);
                #1;
                budget--;
            end
            check_ok("frame_completes_in_budget", budget > 0, frames_done - f0, nframes);
        end
    endtask

    task automatic load_golden_pixels();
        tx_q.delete();
        tx_q.push_back(32'h3F80_0000);
        tx_q.push_back(32'h4000_0000);
        tx_q.push_back(32'h4040_0000);
        tx_q.push_back(32'h4080_0000);
    endtask

    task automatic check_golden(input string name);
        check({name, "_count"}, cap_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < cap_q.size()) check(name, cap_q[i], GOLDEN[i]);
        end
    endtask

    initial begin
        int budget;
        rst = 1'b1; valid_in = 1'b0; data_in = '0;
        b_valid = 1'b0; b_data = '0; b_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        load_golden_pixels(); cap_q.delete();
        send_frames(1, 0, 0, -1, 0);
        check_golden("continuous");

        load_golden_pixels(); cap_q.delete();
        send_frames(1, 0, 0, 5, 0);
        check_golden("fifo_stall");

        load_golden_pixels(); cap_q.delete();
        send_frames(1, 2, 0, -1, 0);
        check_golden("valid_gaps");

        load_golden_pixels();
        send_frames(1, 0, 0, -1, 7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_after_reset", 32'(wrreq), 0);
        end
        @(posedge clk);
        #1;
        load_golden_pixels(); cap_q.delete();
        send_frames(1, 0, 0, -1, 0);
        check_golden("after_reset");

        tx_q.delete();
        tx_q.push_back(32'hBF80_0000);
        tx_q.push_back(32'h3F80_0000);
        tx_q.push_back(32'h4000_0000);
        tx_q.push_back(32'h4040_0000);
        cap_q.delete();
        send_frames(1, 0, 0, -1, 0);
        check("neg_pixel_count", cap_q.size(), 16);
`ifdef FEATUREMAP_PAD_RELU_EN
        if (cap_q.size() > 5) check("neg_pixel_relu", cap_q[5], 32'h0);
`else
        if (cap_q.size() > 5) check("neg_pixel_pass", cap_q[5], 32'hBF80_0000);
`endif

        // Back-to-back random frames with random stalls and gaps.
        stall_pct = 30;
        tx_q.delete();
        for (int i = 0; i < 5 * W * H; i++) tx_q.push_back($urandom);
        send_frames(5, 3, 1, -1, 0);
        stall_pct = 0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < BW * BH; i++) btx.push_back($urandom);
        budget = 40000;
        while (btx.size() > 0 && budget > 0) begin
            b_valid = ($urandom_range(3) != 0);
            b_data  = b_valid ? btx[0] : $urandom;
            b_full  = ($urandom_range(99) < 30);
            @(negedge clk);
            if (b_valid && b_ready) void'(btx.pop_front());
            @(posedge clk);
            #1;
            budget--;
        end
        b_valid = 1'b0;
        b_full  = 1'b0;
        while (b_dones == 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        repeat (20) @(posedge clk);
        #1;
        check_ok("big_frame_in_budget", budget > 0, b_dones, 1);
        check("big_writes", b_writes, BTOTAL);
        check("big_handshakes", b_hs, BW * BH);
        check("big_frame_done", b_dones, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/featuremap_pad_writer.md
FEATUREMAP_PAD_WRITER -- requirements
Module: featuremap_pad_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width (IEEE-754 single).
REQ-002 SHALL have parameter WIDTH, default 56, unpadded feature-map columns.
REQ-003 SHALL have parameter HEIGHT, default 56, unpadded feature-map rows.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_in  input  1  upstream pixel valid.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  upstream pixel, raster order.
REQ-008 SHALL have port in_ready  output  1  pixel accepted this cycle when valid_in && in_ready.
REQ-009 SHALL have port fifo_full  input  1  downstream channel FIFO almost-full (asserted at <=1 free entry).
REQ-010 SHALL have port wrreq  output  1  registered FIFO write strobe.
REQ-011 SHALL have port wr_data  output  DATA_WIDTH  registered FIFO write word.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after last padded word written.

Function
REQ-013 SHALL emit one padded frame of (WIDTH+2)*(HEIGHT+2) words in raster order: row r 0..HEIGHT+1, column c 0..WIDTH+1.
REQ-014 SHALL write 32'h0000_0000 at border positions (r==0, r==HEIGHT+1, c==0, c==WIDTH+1) and the next accepted input pixel at interior positions.
REQ-015 SHALL implement states IDLE, PAD, DATA, DONE.
REQ-016 IDLE: in_ready=0, no writes; -> PAD when valid_in=1 (pixel held upstream, not consumed), r=c=0.
REQ-017 PAD: each cycle with fifo_full=0 SHALL write zero and advance (c,r); -> DATA when next position is interior; -> DONE after writing (HEIGHT+1, WIDTH+1).
REQ-018 DATA: in_ready = ~fifo_full; each handshake SHALL write data_in and advance; -> PAD after c==WIDTH written.
REQ-019 in_ready SHALL be 0 in every state except DATA.
REQ-020 fifo_full=1 SHALL stall position counters and force next wrreq=0; no word dropped or duplicated.
REQ-021 DATA with valid_in=0 SHALL stall with wrreq=0.
REQ-022 wrreq/wr_data SHALL lag the accept decision by exactly 1 cycle.
REQ-023 DONE: frame_done=1 for exactly one cycle, no writes, -> IDLE; back-to-back frames allowed (valid_in in DONE ignored until IDLE).
REQ-024 Column counter SHALL wrap WIDTH+1 -> 0 with row increment; counters sized $clog2(WIDTH+2), $clog2(HEIGHT+2).

Reset
REQ-025 rst=1 SHALL force IDLE, r=c=0, wrreq=0, wr_data=0, in_ready=0, frame_done=0 at next edge.
REQ-026 rst mid-frame SHALL abandon the partial frame; no further writes until a new frame starts.

Configuration
REQ-027 Macro FEATUREMAP_PAD_RELU_EN defined: interior pixels with sign bit 1 SHALL be written as 32'h0 (ReLU); padding unchanged.
REQ-028 Macro FEATUREMAP_PAD_RELU_EN undefined: interior pixels SHALL pass unmodified.

Verification (WIDTH=2, HEIGHT=2 unless noted)
REQ-029 Pixels 1.0,2.0,3.0,4.0 continuous, fifo_full=0 -> 16 writes: 0,0,0,0, 0,1.0,2.0,0, 0,3.0,4.0,0, 0,0,0,0; frame_done 1 cycle after last write.
REQ-030 fifo_full=1 for 3 cycles during interior row 1 -> same 16-word sequence, wrreq=0 those cycles, in_ready=0.
REQ-031 valid_in gaps of 2 cycles between pixels -> same sequence, no zero inserted at interior positions.
REQ-032 rst pulsed after 7th write -> outputs 0, IDLE; fresh frame then yields full correct 16 words.
REQ-033 FEATUREMAP_PAD_RELU_EN set, pixel 32'hBF80_0000 (-1.0) -> written 32'h0; unset -> written 32'hBF80_0000.
REQ-034 Default WIDTH=HEIGHT=56, random stall pattern -> exactly 3364 writes, 3136 handshakes, one frame_done.
